// File: rtl/arb_2to1_if.sv
// Handshake bundle between the round-robin arbiter, the two requesting cores,
// the memory side and the shared-path mux select.
interface arb_2to1_if;
  logic req1;
  logic req2;
  logic mem_ack;
  logic sel;
  logic gnt1;
  logic gnt2;
  logic mem_req;
  logic done1;
  logic done2;
  logic err;

  // master: the arbiter, which owns the mux select and the grants
  modport master (
    input  req1, req2, mem_ack,
    output sel, gnt1, gnt2, mem_req, done1, done2, err
  );

  // slave: cores plus memory, which request and acknowledge
  modport slave (
    output req1, req2, mem_ack,
    input  sel, gnt1, gnt2, mem_req, done1, done2, err
  );
endinterface

// File: rtl/arb_2to1.sv
// Two-requester round-robin arbiter driving the shared-path mux select.
// Holds each grant until mem_ack or TIMEOUT cycles, then one GAP cycle.
module arb_2to1 #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = $clog2(TIMEOUT)
) (
  input  logic        clk,
  input  logic        rst_n,
  arb_2to1_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 last_q, last_d;   // 0: core 1 served last, 1: core 2
  logic                 sel_q, sel_d;
  logic                 gnt1_q, gnt1_d;
  logic                 gnt2_q, gnt2_d;
  logic                 mem_req_q, mem_req_d;
  logic                 done1_q, done1_d;
  logic                 done2_q, done2_d;
  logic                 err_q, err_d;
  logic                 pick2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      gnt1_q    <= 1'b0;
      gnt2_q    <= 1'b0;
      mem_req_q <= 1'b0;
      done1_q   <= 1'b0;
      done2_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      gnt1_q    <= gnt1_d;
      gnt2_q    <= gnt2_d;
      mem_req_q <= mem_req_d;
      done1_q   <= done1_d;
      done2_q   <= done2_d;
      err_q     <= err_d;
    end
  end

  // Core 2 wins when it is the sole requester, or on a tie when core 1 went last
  assign pick2 = bus.req2 && (!bus.req1 || !last_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    sel_d     = sel_q;
    gnt1_d    = gnt1_q;
    gnt2_d    = gnt2_q;
    mem_req_d = mem_req_q;
    done1_d   = 1'b0;
    done2_d   = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req1 || bus.req2) begin
          gnt1_d    = !pick2;
          gnt2_d    = pick2;
          sel_d     = pick2;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ack || cnt_q == CNT_MAX) begin
          // Ack takes priority over a coincident timeout
          done1_d   = bus.mem_ack && !sel_q;
          done2_d   = bus.mem_ack && sel_q;
          err_d     = !bus.mem_ack;
          gnt1_d    = 1'b0;
          gnt2_d    = 1'b0;
          mem_req_d = 1'b0;
          last_d    = sel_q;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.sel     = sel_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.gnt2    = gnt2_q;
  assign bus.mem_req = mem_req_q;
  assign bus.done1   = done1_q;
  assign bus.done2   = done2_q;
  assign bus.err     = err_q;

endmodule

// File: doc/arb_2to1.md
# arb_2to1

Two-requester round-robin arbiter that owns the select line of the shared-path `mux_2to1` in front of the memory hierarchy. Core 1 and core 2 raise requests, and the block grants one of them. It drives `sel` so the mux forwards the winner's `din1`/`din2` to the memory side, then holds the grant until memory acknowledges or a timeout expires. It sits directly upstream of `mux_2to1`: its `sel` feeds the mux `sel`, and its `mem_req` accompanies the mux `dout`.

## Interface
- `TIMEOUT`, default 16: maximum BUSY cycles without `mem_ack` before abort; legal range 2..256.
- `CNT_WIDTH`, default `$clog2(TIMEOUT)`: width of the hold counter. Derived; not overridden.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req1`  in  1  request from core 1, whose data is on mux `din1`.
- `req2`  in  1  request from core 2, whose data is on mux `din2`.
- `mem_ack`  in  1  one-cycle acknowledge from the memory side.
- `sel`  out  1  mux select: 0 forwards `din1`, 1 forwards `din2`.
- `gnt1`  out  1  core 1 owns the path.
- `gnt2`  out  1  core 2 owns the path.
- `mem_req`  out  1  valid request on mux `dout` toward memory.
- `done1`  out  1  one-cycle completion pulse to core 1.
- `done2`  out  1  one-cycle completion pulse to core 2.
- `err`  out  1  one-cycle timeout pulse; the owner is identified by `sel`.

## Operation
- All outputs are registered. States: IDLE, BUSY, GAP.
- Reset values:
  - state IDLE, `sel`=0, all other outputs 0, counter 0.
  - `last` (last-served pointer) = 2, so core 1 wins the first tie.
- IDLE:
  - Only `req1`: grant core 1. Only `req2`: grant core 2.
  - Both: grant the core not equal to `last`.
  - Neither: stay in IDLE, `sel` holds its previous value.
  - Grant edge: set the winner's `gntX`=1, `mem_req`=1, `sel` (0 for core 1, 1 for core 2), counter=0, go to BUSY.
- BUSY:
  - `gntX`, `mem_req` and `sel` are held constant.
  - `mem_ack`=1: clear `gntX` and `mem_req`, pulse `doneX`, set `last` to the owner, go to GAP.
  - Else if counter == `TIMEOUT`-1: clear `gntX` and `mem_req`, pulse `err` (no `doneX`), set `last` to the owner, go to GAP.
  - Else: counter+1.
- GAP: exactly one cycle with all grants low, then IDLE. `done`/`err` drop at the GAP→IDLE edge.
- Requesters drop `req` on seeing `done`. A `req` still high in IDLE is a new request.
- Boundary rules:
  - `mem_ack` and the timeout condition in the same cycle: ack wins, no `err`.
  - `mem_ack` in IDLE or GAP: ignored, no state change, no pulses.
  - `req` deasserted mid-BUSY: ignored; the transaction runs to ack or timeout.
  - Never assert `gnt1` and `gnt2` together. At most one of `done1`, `done2`, `err` is high in any cycle.
  - Reset mid-BUSY: all outputs return to reset values immediately (asynchronous), `last`=2. No `done` or `err` is emitted.
  - Counter never wraps; it saturates at `TIMEOUT`-1 because the abort fires there.

## Timing
- Grant latency: `req` first sampled high at edge N → `gntX`, `mem_req`, `sel` valid after edge N.
- The mux sees the new `sel` in the same cycle `mem_req` rises. `sel` is stable for the entire BUSY period.
- Completion: `mem_ack` sampled at edge E → `doneX`=1 and `gntX`=`mem_req`=0 after edge E. `doneX`=0 after edge E+1.
- Back-to-back: the earliest next grant is after edge E+2, a one-cycle bubble.
- Timeout: grant at edge N with no ack → `err` after edge N+`TIMEOUT`.
- Throughput with immediate ack: one transaction per 3 cycles.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles with `req1`=`req2`=1 → all outputs 0, `sel`=0. Release → `gnt1`=1 one edge later (core 1 wins the tie).
- **Fairness:** hold `req1`=`req2`=1 and ack each transaction 2 cycles after grant → grants alternate 1,2,1,2. `sel` sequence is 0,1,0,1, with exactly one GAP cycle between grants.
- **Single requester:**
  - `req2` only, ack 3 cycles after grant → `gnt2`, `mem_req` and `sel`=1 high for 3 cycles, then `done2` for 1 cycle.
  - Then `req2` again → core 2 is re-granted (no starvation by `last`).
- **Timeout:** `TIMEOUT`=16, `req1` with no ack → `err` after exactly 16 BUSY cycles, no `done1`, `gnt1` low. Ack on cycle 16 instead → `done1`, no `err`.
- **Stray ack and early drop:**
  - `mem_ack` pulsed in IDLE → no change on any output.
  - `req1` dropped 1 cycle after grant → `gnt1` is held until ack.
- **Asynchronous reset mid-BUSY:** assert `rst_n`=0 mid-cycle during BUSY → outputs clear before the next edge. After release, with both requesting, core 1 is granted.
